// File: rtl/reg_map_pkg.sv
// Register map and shared types for the ILA trigger sequencer.
// Stage registers sit at a fixed stride above the control/status pair.
package reg_map_pkg;

    localparam logic [31:0] R_ILA_TRIG_CTRL       = 32'h0000_0100;
    localparam logic [31:0] R_ILA_TRIG_STATUS     = 32'h0000_0104;
    localparam logic [31:0] R_ILA_TRIG_STAGE_BASE = 32'h0000_0110;
    localparam logic [31:0] R_ILA_TRIG_STRIDE     = 32'h0000_0010;
    localparam logic [31:0] R_ILA_TRIG_MASK_OFS   = 32'h0000_0000;
    localparam logic [31:0] R_ILA_TRIG_VALUE_OFS  = 32'h0000_0004;
    localparam logic [31:0] R_ILA_TRIG_COUNT_OFS  = 32'h0000_0008;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } ila_trig_state_t;

    function automatic logic [31:0] ila_trig_stage_base(input int k);
        return R_ILA_TRIG_STAGE_BASE + (32'(k) * R_ILA_TRIG_STRIDE);
    endfunction

endpackage

// File: rtl/ila_trig_stage.sv
// One sequencer stage: mask/value/count registers and the match term.
// Read data is zero unless the address hits one of this stage's registers.
module ila_trig_stage #(
    parameter int WIDTH = 32,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      bus_addr,
    input  logic             bus_wen,
    input  logic [31:0]      bus_wdata,
    input  logic [WIDTH-1:0] sample_in,
    output logic             hit,
    output logic [15:0]      count,
    output logic             consec,
    output logic [31:0]      rdata
);
    import reg_map_pkg::*;

    localparam logic [31:0] BASE = ila_trig_stage_base(IDX);
    localparam logic [31:0] A_MASK = BASE + R_ILA_TRIG_MASK_OFS;
    localparam logic [31:0] A_VALUE = BASE + R_ILA_TRIG_VALUE_OFS;
    localparam logic [31:0] A_COUNT = BASE + R_ILA_TRIG_COUNT_OFS;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] value;
    logic [16:0]      cfg;

    // Bus writes to this stage's configuration registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask  <= '0;
            value <= '0;
            cfg   <= '0;
        end else if (bus_wen) begin
            if (bus_addr == A_MASK)  mask  <= bus_wdata[WIDTH-1:0];
            if (bus_addr == A_VALUE) value <= bus_wdata[WIDTH-1:0];
            if (bus_addr == A_COUNT) cfg   <= bus_wdata[16:0];
        end
    end

    assign hit    = (sample_in & mask) == (value & mask);
    assign count  = cfg[15:0];
    assign consec = cfg[16];

    // Read mux for this stage's registers
    always_comb begin
        rdata = '0;
        if (bus_addr == A_MASK)  rdata = 32'(mask);
        if (bus_addr == A_VALUE) rdata = 32'(value);
        if (bus_addr == A_COUNT) rdata = 32'(cfg);
    end

endmodule

// File: rtl/ila_trigger_seq.sv
// Multi-stage trigger sequencer feeding the ILA trigger input.
// Stage matches come from ila_trig_stage; FSM and counter live here.
module ila_trigger_seq #(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    output logic             trigger_out,
    output logic             armed,
    input  logic [31:0]      bus_addr,
    input  logic             bus_wen,
    input  logic             bus_ren,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata
);
    import reg_map_pkg::*;

    localparam logic [1:0] MAX_STAGE = 2'(NUM_STAGES - 1);

    ila_trig_state_t state;
    logic [1:0]      stage;
    logic [15:0]     cnt;
    logic            fired;
    logic            arm_bit;
    logic [1:0]      last_stage;

    logic [3:0]  hit;
    logic [15:0] cfg_count [4];
    logic [3:0]  cfg_consec;
    logic [31:0] stage_rdata [4];

    logic        ctrl_wr;
    logic [1:0]  ls_req;
    logic [1:0]  ls_new;
    logic        unused_ren;

    assign unused_ren = bus_ren;

    for (genvar k = 0; k < 4; k++) begin : g_stage
        if (k < NUM_STAGES) begin : g_on
            ila_trig_stage #(
                .WIDTH (WIDTH),
                .IDX   (k)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .bus_addr  (bus_addr),
                .bus_wen   (bus_wen),
                .bus_wdata (bus_wdata),
                .sample_in (sample_in),
                .hit       (hit[k]),
                .count     (cfg_count[k]),
                .consec    (cfg_consec[k]),
                .rdata     (stage_rdata[k])
            );
        end else begin : g_off
            assign hit[k]         = 1'b0;
            assign cfg_count[k]   = '0;
            assign cfg_consec[k]  = 1'b0;
            assign stage_rdata[k] = '0;
        end
    end

    assign ctrl_wr = bus_wen && (bus_addr == R_ILA_TRIG_CTRL);
    assign ls_req  = bus_wdata[3:2];
    assign ls_new  = (ls_req > MAX_STAGE) ? MAX_STAGE : ls_req;
    assign armed   = (state == ARMED);

    // Sequencer FSM: control writes win over sample evaluation
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            stage       <= '0;
            cnt         <= '0;
            fired       <= 1'b0;
            arm_bit     <= 1'b0;
            last_stage  <= '0;
            trigger_out <= 1'b0;
        end else begin
            trigger_out <= 1'b0;
            if (ctrl_wr) begin
                arm_bit    <= bus_wdata[0];
                last_stage <= ls_new;
                stage      <= '0;
                cnt        <= '0;
                if (!bus_wdata[0]) begin
                    state <= IDLE;
                end else if (bus_wdata[8]) begin
                    state       <= FIRED;
                    fired       <= 1'b1;
                    trigger_out <= (state != FIRED);
                end else begin
                    state <= ARMED;
                    fired <= 1'b0;
                end
            end else if (state == ARMED) begin
                if (hit[stage]) begin
                    if (cnt == cfg_count[stage]) begin
                        cnt <= '0;
                        if (stage == last_stage) begin
                            state       <= FIRED;
                            fired       <= 1'b1;
                            trigger_out <= 1'b1;
                        end else begin
                            stage <= stage + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end else if (cfg_consec[stage]) begin
                    cnt <= '0;
                end
            end
        end
    end

    // Register read mux, no wait states
    always_comb begin
        bus_rdata = stage_rdata[0] | stage_rdata[1]
                  | stage_rdata[2] | stage_rdata[3];
        if (bus_addr == R_ILA_TRIG_CTRL)
            bus_rdata = {28'd0, last_stage, 1'b0, arm_bit};
        if (bus_addr == R_ILA_TRIG_STATUS)
            bus_rdata = {cnt, 10'd0, stage, 2'd0, fired, armed};
    end

endmodule

// File: tb/tb_ila_trigger_seq.sv
// Directed bench for ila_trigger_seq: vector tables plus
// hand-written sequences for arm/force/disarm/reset corners.
module tb_ila_trigger_seq;

    localparam logic [31:0] A_CTRL   = 32'h100;
    localparam logic [31:0] A_STATUS = 32'h104;
    localparam logic [31:0] A_MASK0  = 32'h110;
    localparam logic [31:0] A_VALUE0 = 32'h114;
    localparam logic [31:0] A_COUNT0 = 32'h118;
    localparam logic [31:0] A_MASK1  = 32'h120;
    localparam logic [31:0] A_VALUE1 = 32'h124;
    localparam logic [31:0] A_COUNT1 = 32'h128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sample_in = '0;
    logic        trigger_out;
    logic        armed;
    logic [31:0] bus_addr = '0;
    logic        bus_wen = 1'b0;
    logic        bus_ren = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] sample;
        logic        trig;
        logic [31:0] status;
    } vec_t;

    vec_t vecs [13];

    ila_trigger_seq #(
        .WIDTH      (32),
        .NUM_STAGES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .trigger_out (trigger_out),
        .armed       (armed),
        .bus_addr    (bus_addr),
        .bus_wen     (bus_wen),
        .bus_ren     (bus_ren),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a,
                           input logic [31:0] exp);
        bus_addr = a;
        bus_ren  = 1'b1;
        #1;
        chk(name, bus_rdata, exp);
        bus_ren  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_wen   = 1'b1;
        @(posedge clk);
        #1;
        bus_wen   = 1'b0;
    endtask

    task automatic step(input logic [31:0] s);
        @(negedge clk);
        sample_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].sample);
            chk($sformatf("%s[%0d].trig", tag, i),
                32'(trigger_out), 32'(vecs[i].trig));
            chk_reg($sformatf("%s[%0d].status", tag, i),
                    A_STATUS, vecs[i].status);
        end
    endtask

    initial begin
        // two-stage: 0x1 then 0x2
        vecs[0]  = '{32'h2, 1'b0, 32'h0000_0001};
        vecs[1]  = '{32'h1, 1'b0, 32'h0000_0011};
        vecs[2]  = '{32'h3, 1'b0, 32'h0000_0011};
        vecs[3]  = '{32'h2, 1'b1, 32'h0000_0012};
        vecs[4]  = '{32'h2, 1'b0, 32'h0000_0012};
        // count 2, consecutive
        vecs[5]  = '{32'h33, 1'b0, 32'h0001_0001};
        vecs[6]  = '{32'h33, 1'b0, 32'h0002_0001};
        vecs[7]  = '{32'h00, 1'b0, 32'h0000_0001};
        vecs[8]  = '{32'h33, 1'b0, 32'h0001_0001};
        // count 2, non-consecutive
        vecs[9]  = '{32'h33, 1'b0, 32'h0001_0001};
        vecs[10] = '{32'h33, 1'b0, 32'h0002_0001};
        vecs[11] = '{32'h00, 1'b0, 32'h0002_0001};
        vecs[12] = '{32'h33, 1'b1, 32'h0000_0002};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.trig", 32'(trigger_out), 32'h0);
        chk("rst.armed", 32'(armed), 32'h0);
        chk_reg("rst.status", A_STATUS, 32'h0);
        rst = 1'b1;
        step(32'h0);

        // single stage equality
        wr(A_MASK0, 32'hFF);
        wr(A_VALUE0, 32'h5A);
        wr(A_COUNT0, 32'h0);
        chk_reg("cfg.mask0", A_MASK0, 32'hFF);
        chk_reg("unmapped", 32'h200, 32'h0);
        wr(A_CTRL, 32'h1);
        chk("s1.armed", 32'(armed), 32'h1);
        chk_reg("s1.ctrl", A_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(32'h00);
            chk($sformatf("s1.quiet%0d", i), 32'(trigger_out), 32'h0);
        end
        step(32'h5A);
        chk("s1.pulse", 32'(trigger_out), 32'h1);
        chk_reg("s1.status", A_STATUS, 32'h2);
        step(32'h5A);
        chk("s1.nopulse", 32'(trigger_out), 32'h0);

        // two-stage sequence
        wr(A_CTRL, 32'h0);
        wr(A_MASK0, 32'hF);
        wr(A_VALUE0, 32'h1);
        wr(A_MASK1, 32'hF);
        wr(A_VALUE1, 32'h2);
        wr(A_COUNT1, 32'h0);
        wr(A_CTRL, 32'h5);
        chk_reg("s2.ctrl", A_CTRL, 32'h4 | 32'h1);
        run_vecs(0, 4, "seq2");

        // count 2 consecutive
        wr(A_CTRL, 32'h0);
        wr(A_MASK0, 32'hFF);
        wr(A_VALUE0, 32'h33);
        wr(A_COUNT0, 32'h0001_0002);
        wr(A_CTRL, 32'h1);
        run_vecs(5, 8, "cons");

        // count 2 non-consecutive
        wr(A_CTRL, 32'h0);
        wr(A_COUNT0, 32'h0000_0002);
        wr(A_CTRL, 32'h1);
        run_vecs(9, 12, "ncons");

        // arm write in the same cycle as a matching sample
        wr(A_CTRL, 32'h0);
        wr(A_MASK0, 32'hFF);
        wr(A_VALUE0, 32'h77);
        wr(A_COUNT0, 32'h0);
        step(32'h77);
        wr(A_CTRL, 32'h1);
        chk("armsim.nopulse", 32'(trigger_out), 32'h0);
        chk("armsim.armed", 32'(armed), 32'h1);
        step(32'h77);
        chk("armsim.pulse", 32'(trigger_out), 32'h1);

        // disarm during stage 1
        wr(A_CTRL, 32'h0);
        wr(A_MASK0, 32'hF);
        wr(A_VALUE0, 32'h1);
        wr(A_COUNT1, 32'h5);
        wr(A_CTRL, 32'h5);
        step(32'h1);
        step(32'h2);
        step(32'h2);
        chk_reg("dis.pre", A_STATUS, 32'h0002_0011);
        sample_in = 32'h2;
        wr(A_CTRL, 32'h0);
        chk("dis.trig", 32'(trigger_out), 32'h0);
        chk_reg("dis.status", A_STATUS, 32'h0);
        step(32'h2);
        chk("dis.idle", 32'(trigger_out), 32'h0);

        // forced fire
        wr(A_CTRL, 32'h1);
        step(32'h0);
        wr(A_CTRL, 32'h101);
        chk("force.pulse", 32'(trigger_out), 32'h1);
        chk_reg("force.status", A_STATUS, 32'h2);
        chk_reg("force.ctrl", A_CTRL, 32'h1);
        step(32'h0);
        chk("force.once", 32'(trigger_out), 32'h0);

        // mask 0 always matches, FIRED is terminal, re-arm works
        wr(A_CTRL, 32'h0);
        wr(A_MASK0, 32'h0);
        wr(A_VALUE0, 32'hAB);
        wr(A_COUNT0, 32'h0);
        wr(A_CTRL, 32'h1);
        chk("m0.arm", 32'(trigger_out), 32'h0);
        step(32'h123);
        chk("m0.pulse", 32'(trigger_out), 32'h1);
        step(32'h456);
        chk("m0.term1", 32'(trigger_out), 32'h0);
        step(32'h789);
        chk("m0.term2", 32'(trigger_out), 32'h0);
        wr(A_CTRL, 32'h1);
        chk("m0.rearm", 32'(trigger_out), 32'h0);
        chk_reg("m0.rearm.status", A_STATUS, 32'h1);
        step(32'h0);
        chk("m0.repulse", 32'(trigger_out), 32'h1);

        // reset mid-count at stage 1, counter 3
        wr(A_CTRL, 32'h0);
        wr(A_MASK0, 32'hF);
        wr(A_VALUE0, 32'h1);
        wr(A_COUNT1, 32'h5);
        wr(A_CTRL, 32'h5);
        step(32'h1);
        step(32'h2);
        step(32'h2);
        step(32'h2);
        chk_reg("rst2.pre", A_STATUS, 32'h0003_0011);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2.trig", 32'(trigger_out), 32'h0);
        chk_reg("rst2.status", A_STATUS, 32'h0);
        chk_reg("rst2.mask0", A_MASK0, 32'h0);
        chk_reg("rst2.value1", A_VALUE1, 32'h0);
        chk_reg("rst2.count1", A_COUNT1, 32'h0);
        chk_reg("rst2.ctrl", A_CTRL, 32'h0);
        rst = 1'b1;
        step(32'h2);
        chk("rst2.after", 32'(trigger_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
